seg_scan_ctrl: RTL and testbench

Time-multiplexed controller for the board's 8-digit seven-segment display. Holds a per-digit register file (enable, BCD/hex nibble, dot), scans one digit at a time through a single shared `bcd2seg` decoder instance, and drives one-hot active-low digit selects. Writers (keyboard scan-code path, counters, debug) update digits through a valid/ready port. Sits between the datapath and the display pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd2seg.sv | 38 +++
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
// A register-file entry packs {ena, bcd[3:0], dot}.
package seg_pkg;

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned ENTRY_W = 6;
  localparam int unsigned ENA_BIT = 5;
  localparam int unsigned BCD_LSB = 1;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned DOT_BIT = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(input logic ena, input logic [3:0] bcd, input logic dot);
    return {ena, bcd, dot};
  endfunction

endpackage

// File: rtl/bcd2seg.sv
// Nibble to seven-segment decoder; output is active-low {a..g, dp}, fully blank when disabled.
module bcd2seg
  import seg_pkg::*;
(
  input  logic       ena,
  input  logic [3:0] bcd,
  input  logic       dot,
  output logic [7:0] seg
);

  logic [6:0] abcdefg;

  always_comb begin
    abcdefg = 7'b0000000;
    unique case (bcd)
      4'h0: abcdefg = 7'b1111110;
      4'h1: abcdefg = 7'b0110000;
      4'h2: abcdefg = 7'b1101101;
      4'h3: abcdefg = 7'b1111001;
      4'h4: abcdefg = 7'b0110011;
      4'h5: abcdefg = 7'b1011011;
      4'h6: abcdefg = 7'b1011111;
      4'h7: abcdefg = 7'b1110000;
      4'h8: abcdefg = 7'b1111111;
      4'h9: abcdefg = 7'b1111011;
      4'hA: abcdefg = 7'b1110111;
      4'hB: abcdefg = 7'b0011111;
      4'hC: abcdefg = 7'b1001110;
      4'hD: abcdefg = 7'b0111101;
      4'hE: abcdefg = 7'b1001111;
      4'hF: abcdefg = 7'b1000111;
      default: abcdefg = 7'b0000000;
    endcase
  end

  assign seg = ena ? ~{abcdefg, dot} : SEG_BLANK;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment controller: per-digit register file, one shared
// decoder, blink support and a valid/ready write port with a bulk-clear sequence.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DIGITS)-1:0] wr_idx,
  input  logic [3:0]                wr_bcd,
  input  logic                      wr_ena,
  input  logic                      wr_dot,
  input  logic                      clr_all,
  input  logic [DIGITS-1:0]         blink_mask,
  output logic [DIGITS-1:0]         an_n,
  output logic [7:0]                seg,
  output logic                      frame_tick
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  clr_k_q;
  entry_t            rf_q [DIGITS];

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              frame_tick_q;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic [7:0]        seg_q, seg_dec;

  logic              div_wrap, idx_wrap;
  logic              wr_fire, wr_in_range;
  logic              eff_ena;
  entry_t            cur;

  // Write port: a clear request in the same cycle takes priority over the write.
  assign wr_ready    = (state_q == SCAN) & ~clr_all;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = 32'(wr_idx) < DIGITS;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= SCAN;
      clr_k_q <= '0;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (clr_all) begin
            state_q <= CLEAR;
            clr_k_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_k_q == IDX_LAST) begin
            state_q <= SCAN;
          end
          clr_k_q <= clr_k_q + IDX_W'(1);
        end
        default: begin
          state_q <= SCAN;
          clr_k_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      rf_q[clr_k_q] <= '0;
    end else if (wr_fire && wr_in_range) begin
      rf_q[wr_idx] <= pack_entry(wr_ena, wr_bcd, wr_dot);
    end
  end

  always_comb begin
    div_wrap      = (div_q == DIV_LAST);
    idx_wrap      = div_wrap && (idx_q == IDX_LAST);
    div_d         = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d         = idx_q;
    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    if (div_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (idx_wrap) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
    // Selects follow the next divider value so an_n lines up with div; first slot is dead time.
    an_n_d = (div_d == '0) ? '1 : ~(DIGITS'(1) << idx_d);
  end

  assign cur     = rf_q[idx_q];
  assign eff_ena = cur[ENA_BIT] & ~(blink_mask[idx_q] & blink_phase_q);

  bcd2seg u_bcd2seg (
    .ena (eff_ena),
    .bcd (cur[BCD_LSB +: BCD_W]),
    .dot (cur[DOT_BIT]),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_q         <= '0;
      idx_q         <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      an_n_q        <= '1;
      seg_q         <= SEG_BLANK;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= idx_wrap;
      an_n_q        <= an_n_d;
      seg_q         <= seg_dec;
    end
  end

  assign an_n       = an_n_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=8, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS       = 8;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b0;
  logic       wr_valid   = 1'b0;
  logic [2:0] wr_idx     = '0;
  logic [3:0] wr_bcd     = '0;
  logic       wr_ena     = 1'b0;
  logic       wr_dot     = 1'b0;
  logic       clr_all    = 1'b0;
  logic [7:0] blink_mask = '0;
  logic       wr_ready;
  logic [7:0] an_n;
  logic [7:0] seg;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;
  logic [7:0] exp_seg [8];

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_bcd     (wr_bcd),
    .wr_ena     (wr_ena),
    .wr_dot     (wr_dot),
    .clr_all    (clr_all),
    .blink_mask (blink_mask),
    .an_n       (an_n),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Active edges seen since the last reset release.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %02h, want %02h (edges=%0d)", tag, got, want, edges);
    end
  endtask

  task automatic do_write(input logic [2:0] i, input logic [3:0] b, input logic e,
                          input logic d);
    @(negedge clk);
    wr_idx   = i;
    wr_bcd   = b;
    wr_ena   = e;
    wr_dot   = d;
    wr_valid = 1'b1;
    #1;
    check_eq("write wr_ready", {7'b0, wr_ready}, 8'h01);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // One full frame: digit select, frame tick and selected-digit segments every cycle.
  task automatic check_frame(input string tag);
    int div;
    int idx;
    int phase;
    logic [7:0] want;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      div = edges % 4;
      idx = (edges / 4) % 8;
      check_eq({tag, " an_n"}, an_n, (div == 0) ? 8'hFF : ~(8'h01 << idx));
      check_eq({tag, " frame_tick"}, {7'b0, frame_tick},
               {7'b0, (edges % 32 == 0) && (edges > 0)});
      if (div != 0) begin
        phase = ((edges - 1) / 64) % 2;
        want  = (blink_mask[idx] && phase == 1) ? 8'hFF : exp_seg[idx];
        check_eq({tag, " seg"}, seg, want);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_seg[i] = 8'hFF;

    repeat (3) @(negedge clk);
    check_eq("reset an_n", an_n, 8'hFF);
    check_eq("reset seg", seg, 8'hFF);
    check_eq("reset frame_tick", {7'b0, frame_tick}, 8'h00);
    clrn = 1'b1;
    #1;
    check_eq("release wr_ready", {7'b0, wr_ready}, 8'h01);
    check_eq("release an_n", an_n, 8'hFF);
    check_frame("blank");

    do_write(3'd3, 4'h5, 1'b1, 1'b0);
    exp_seg[3] = 8'h49;
    check_frame("digit3");

    do_write(3'd0, 4'hA, 1'b1, 1'b1);
    exp_seg[0] = 8'h10;
    check_frame("digit0");

    @(negedge clk);
    blink_mask = 8'h01;
    repeat (4) check_frame("blink");
    @(negedge clk);
    blink_mask = 8'h00;

    // Clear and write in the same cycle: clear wins, write to digit 5 is dropped.
    @(negedge clk);
    clr_all  = 1'b1;
    wr_valid = 1'b1;
    wr_idx   = 3'd5;
    wr_bcd   = 4'h7;
    wr_ena   = 1'b1;
    wr_dot   = 1'b0;
    #1;
    check_eq("clr pulse wr_ready", {7'b0, wr_ready}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr_all = 1'b0;
      #1;
      check_eq("clearing wr_ready", {7'b0, wr_ready}, 8'h00);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check_eq("clear done wr_ready", {7'b0, wr_ready}, 8'h01);
    for (int i = 0; i < 8; i++) exp_seg[i] = 8'hFF;
    check_frame("cleared");

    // Fill all digits, then reset partway through a clear.
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'h8, 1'b1, 1'b0);
    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    #1;
    check_eq("midclear an_n", an_n, 8'hFF);
    check_eq("midclear seg", seg, 8'hFF);
    check_eq("midclear frame_tick", {7'b0, frame_tick}, 8'h00);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    #1;
    check_eq("post-reset wr_ready", {7'b0, wr_ready}, 8'h01);
    check_eq("post-reset an_n", an_n, 8'hFF);
    check_frame("post-reset");

    do_write(3'd2, 4'h3, 1'b1, 1'b0);
    do_write(3'd1, 4'h8, 1'b0, 1'b1);
    do_write(3'd7, 4'h8, 1'b1, 1'b1);
    exp_seg[2] = 8'h0D;
    exp_seg[1] = 8'hFF;
    exp_seg[7] = 8'h00;
    check_frame("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
